// File: rtl/qrs_det_pkg.sv
// Shared state type and output field layout for the QRS detector.
package qrs_det_pkg;
  typedef enum logic {LEARN = 1'b0, DETECT = 1'b1} qrs_state_e;

  localparam int RR_LSB  = 16;
  localparam int RR_MSB  = 31;
  localparam int AMP_LSB = 0;
  localparam int AMP_MSB = 15;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;
endpackage

// File: rtl/qrs_peak_finder.sv
// Local-maximum finder: clamps negative samples to zero and flags a candidate
// on the first falling sample after a rise (plateaus report the first-equal value).
module qrs_peak_finder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              smp_vld,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              rise_clr,
  output logic [DATA_W-1:0] smp_clamped,
  output logic              cand_vld,
  output logic [DATA_W-1:0] cand_data
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              rising_q, rising_d;

  always_comb begin
    smp_clamped = smp_data[DATA_W-1] ? '0 : smp_data;
    prev_d      = prev_q;
    rising_d    = rising_q;
    cand_vld    = 1'b0;
    cand_data   = prev_q;
    if (smp_vld) begin
      prev_d = smp_clamped;
      if (smp_clamped > prev_q) begin
        rising_d = 1'b1;
      end else if ((smp_clamped < prev_q) && rising_q) begin
        cand_vld = 1'b1;
        rising_d = 1'b0;
      end
      if (rise_clr) rising_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      rising_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      rising_q <= rising_d;
    end
  end

endmodule

// File: rtl/axis_qrs_detector.sv
// Adaptive-threshold QRS detector emitting {RR, amplitude} beats on AXI-Stream.
// Define QRS_DET_LEARN_EN to seed SPKI/NPKI from a learning window after reset.
//
// state  | meaning
// LEARN  | tracking max sample for LEARN_SAMPLES accepted samples, no beats
// DETECT | classifying candidates as QRS or noise
module axis_qrs_detector
  import qrs_det_pkg::*;
#(
  parameter int                DATA_W          = 32,
  parameter int                REFRACT_SAMPLES = 40,
  parameter logic [DATA_W-1:0] SPKI_INIT       = DATA_W'('h4000),
  parameter logic [DATA_W-1:0] NPKI_INIT       = DATA_W'('h0400),
  parameter int                LEARN_SAMPLES   = 400,
  parameter int                AMP_SHIFT       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [31:0]       m_axis_tdata,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] o_thr
);

`ifdef QRS_DET_LEARN_EN
  localparam bit LEARN_EN = 1'b1;
`else
  localparam bit LEARN_EN = 1'b0;
`endif

  localparam int          LC_W    = (LEARN_SAMPLES > 1) ? $clog2(LEARN_SAMPLES) : 1;
  localparam logic [15:0] REFRACT = 16'(REFRACT_SAMPLES);

  function automatic logic [DATA_W-1:0] thr_of(input logic [DATA_W-1:0] spki,
                                               input logic [DATA_W-1:0] npki);
    logic [DATA_W:0] diff;
    diff = {1'b0, spki} - {1'b0, npki};
    if (spki <= npki) return npki;
    return npki + DATA_W'(diff >> 2);
  endfunction

  qrs_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] spki_q, spki_d, npki_q, npki_d, thr_q, thr_d;
  logic [DATA_W-1:0] mx_q, mx_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic              m_vld_q, m_vld_d;
  logic [31:0]       m_data_q, m_data_d;

  logic              s_ready, accept, rise_clr, cand_vld;
  logic [DATA_W-1:0] smp, cand, amp_full;
  logic [15:0]       amp_sat;

  qrs_peak_finder #(.DATA_W(DATA_W)) u_peak (
    .clk        (clk),
    .rst        (rst),
    .smp_vld    (accept),
    .smp_data   (s_axis_tdata),
    .rise_clr   (rise_clr),
    .smp_clamped(smp),
    .cand_vld   (cand_vld),
    .cand_data  (cand)
  );

  always_comb begin
    s_ready  = !(m_vld_q && !m_axis_tready);
    accept   = s_axis_tvalid && s_ready;
    amp_full = cand >> AMP_SHIFT;
    amp_sat  = (|amp_full[DATA_W-1:16]) ? SAT_MAX : amp_full[15:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    spki_d   = spki_q;
    npki_d   = npki_q;
    mx_d     = mx_q;
    lc_d     = lc_q;
    m_vld_d  = m_vld_q && !m_axis_tready;
    m_data_d = m_data_q;
    rise_clr = 1'b0;

    if (accept) begin
      if (cnt_q != SAT_MAX) cnt_d = cnt_q + 16'd1;
      if (state_q == LEARN) begin
        mx_d = (smp > mx_q) ? smp : mx_q;
        if (lc_q == '0) begin
          state_d  = DETECT;
          spki_d   = mx_d >> 1;
          npki_d   = mx_d >> 3;
          cnt_d    = '0;
          rise_clr = 1'b1;
        end else begin
          lc_d = lc_q - LC_W'(1);
        end
      end else if (cand_vld && (cnt_q >= REFRACT)) begin
        // RR is the count before this sample's increment
        if (cand > thr_q) begin
          spki_d                   = spki_q - (spki_q >> 3) + (cand >> 3);
          m_vld_d                  = 1'b1;
          m_data_d[RR_MSB:RR_LSB]   = cnt_q;
          m_data_d[AMP_MSB:AMP_LSB] = amp_sat;
          cnt_d                    = 16'd1;
        end else begin
          npki_d = npki_q - (npki_q >> 3) + (cand >> 3);
        end
      end
    end

    thr_d = thr_of(spki_d, npki_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LEARN_EN ? LEARN : DETECT;
      cnt_q    <= '0;
      spki_q   <= SPKI_INIT;
      npki_q   <= NPKI_INIT;
      thr_q    <= thr_of(SPKI_INIT, NPKI_INIT);
      mx_q     <= '0;
      lc_q     <= LC_W'(LEARN_SAMPLES - 1);
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      spki_q   <= spki_d;
      npki_q   <= npki_d;
      thr_q    <= thr_d;
      mx_q     <= mx_d;
      lc_q     <= lc_d;
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_data_q;
  assign o_thr         = thr_q;

endmodule

// File: tb/tb_axis_qrs_detector.sv
// Directed + randomized bench for axis_qrs_detector against a behavioural Pan-Tompkins model.
module tb_axis_qrs_detector;

  localparam int LEARN_SAMPLES = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tready = 1'b1;
  logic [31:0] o_thr;

  always #5 clk = ~clk;

  axis_qrs_detector dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tready(m_axis_tready),
    .o_thr        (o_thr)
  );

  int errors = 0;
  int checks = 0;

  longint      m_prev, m_cnt, m_spki, m_npki, m_mx, m_lcnt;
  bit          m_rising, m_learn, m_pend;
  logic [31:0] m_beat;

  int          beats_seen = 0;
  logic [31:0] last_beat = '0;
  int          stall_cnt = 0;
  bit          rand_rdy = 1'b0;
  bit          rand_vld = 1'b0;

  function automatic longint thr_of(input longint s, input longint n);
    return (s <= n) ? n : n + (s - n) / 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_rising = 0; m_pend = 0; m_beat = '0;
    m_spki = 64'h4000; m_npki = 64'h0400; m_mx = 0; m_lcnt = 0;
`ifdef QRS_DET_LEARN_EN
    m_learn = 1;
`else
    m_learn = 0;
`endif
  endtask

  task automatic model_sample(input logic [31:0] d);
    longint cur, rr, cv, amp;
    bit cand;
    cur  = d[31] ? 64'd0 : longint'(d);
    cand = 0;
    cv   = 0;
    if (cur > m_prev) m_rising = 1;
    else if (cur < m_prev && m_rising) begin cand = 1; cv = m_prev; m_rising = 0; end
    m_prev = cur;
    rr = m_cnt;
    if (m_cnt < 65535) m_cnt++;
    if (m_learn) begin
      if (cur > m_mx) m_mx = cur;
      m_lcnt++;
      if (m_lcnt == LEARN_SAMPLES) begin
        m_spki = m_mx / 2; m_npki = m_mx / 8; m_rising = 0; m_cnt = 0; m_learn = 0;
      end
    end else if (cand && rr >= 40) begin
      if (cv > thr_of(m_spki, m_npki)) begin
        m_spki = m_spki - m_spki / 8 + cv / 8;
        amp    = cv / 256;
        if (amp > 65535) amp = 65535;
        m_beat = {16'(rr), 16'(amp)};
        m_pend = 1;
        m_cnt  = 1;
      end else begin
        m_npki = m_npki - m_npki / 8 + cv / 8;
      end
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance model, step the edge.
  task automatic step(input bit vld, input logic [31:0] d, output bit acc);
    bit rdy_in, exp_rdy;
    if (stall_cnt > 0) begin rdy_in = 1'b0; stall_cnt--; end
    else rdy_in = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_axis_tvalid = vld;
    s_axis_tdata  = d;
    m_axis_tready = rdy_in;
    #1;
    exp_rdy = !(m_pend && !rdy_in);
    chk("s_tready", s_axis_tready, exp_rdy);
    chk("m_tvalid", m_axis_tvalid, m_pend);
    if (m_pend) chk("m_tdata", m_axis_tdata, m_beat);
    chk("o_thr", o_thr, thr_of(m_spki, m_npki));
    if (m_axis_tvalid && rdy_in) begin beats_seen++; last_beat = m_axis_tdata; end
    if (m_pend && rdy_in) m_pend = 0;
    acc = vld && exp_rdy;
    if (acc) model_sample(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    while (!acc) begin
      step(rand_vld ? ($urandom_range(0, 3) != 0) : 1'b1, d, acc);
      guard++;
      if (!acc && guard >= 300) begin
        chk("send_timeout", guard, 0);
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    stall_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_thr", o_thr, 32'h1300);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] tri_sample(input int i);
    if (i < 44) return 32'h0;
    if (i < 60) return 32'(i - 43) * 32'h800;
    if (i < 76) return 32'(75 - i) * 32'h800;
    return 32'h0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b0;
    bit  acc;
    model_reset();
    @(negedge clk);
    do_reset();

`ifdef QRS_DET_LEARN_EN
    for (int i = 0; i < 150; i++) send(i == 70 ? 32'h20000 : 32'($urandom_range(0, 32'h3000)));
    do_reset();
    for (int i = 0; i < 399; i++) send(i == 200 ? 32'h10000 : 32'($urandom_range(0, 32'h3000)));
    chk("learn_no_beats", beats_seen, 0);
    chk("learn_thr_hold", o_thr, 32'h1300);
    send(32'h0);
    chk("learn_thr_exit", o_thr, 32'h3800);
`endif

    // triangle pulses every 160 samples, gappy input valid
    rand_vld = 1'b1;
    b0 = beats_seen;
    for (int p = 0; p < 5; p++)
      for (int i = 0; i < 160; i++) send(tri_sample(i));
    for (int i = 0; i < 4; i++) send(32'h0);
    chk("t1_beats", beats_seen - b0, 5);
    chk("t1_last_beat", last_beat, 32'h00A0_0080);

    // refractory: second pulse 20 samples after the first is ignored
    rand_vld = 1'b0;
    for (int i = 0; i < 60; i++) send(32'h0);
    b0 = beats_seen;
    send(32'h8000);
    for (int i = 0; i < 19; i++) send(32'h0);
    send(32'h8000);
    for (int i = 0; i < 60; i++) send(32'h0);
    chk("t2_beats", beats_seen - b0, 1);

    // sub-threshold bumps adapt NPKI only
    rand_rdy = 1'b1;
    b0 = beats_seen;
    for (int b = 0; b < 20; b++) begin
      send(32'h0800);
      for (int i = 0; i < 49; i++) send(32'h0);
    end
    chk("t3_beats", beats_seen - b0, 0);

    // output stall with constant input valid
    rand_rdy = 1'b0;
    for (int i = 0; i < 60; i++) send(32'h0);
    b0 = beats_seen;
    send(32'h8000);
    send(32'h0);
    stall_cnt = 50;
    send(32'h0100);
    chk("t4_stall_done", stall_cnt, 0);
    for (int i = 0; i < 5; i++) send(32'h0);
    chk("t4_beats", beats_seen - b0, 1);

    // long run of negative samples saturates RR
    for (int i = 0; i < 65600; i++) send(32'h8000_0000 | 32'($urandom));
    send(32'h10000);
    send(32'h0);
    send(32'h0);
    chk("t5_rr_sat", last_beat[31:16], 16'hFFFF);
    chk("t5_amp", last_beat[15:0], 16'h0100);

    // reset while a beat is stalled drops it
    for (int i = 0; i < 60; i++) send(32'h0);
    send(32'h40000);
    send(32'h0);
    stall_cnt = 20;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0, acc);
    chk("stall_pending", m_axis_tvalid, 1);
    do_reset();

    // randomized traffic, including amplitude saturation and negative samples
    rand_vld = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) send(32'($urandom));
      else send(32'($urandom_range(0, 32'h18000)));
    end
    for (int i = 0; i < 10; i++) send(32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
